// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the Vespa memory-access stage: datapath widths and FSM states.
package mem_access_stage_pkg;

  localparam int WIDTH = 32;
  localparam int RA_W  = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } memState_e;

endpackage

// File: rtl/mem_access_stage.sv
// Vespa memory stage: turns ALU results into writeback packets or data-memory transactions.
// Optional alignment trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_alu_rslt,
  input  logic [WIDTH-1:0] i_store_data,
  input  logic             i_mem_rd,
  input  logic             i_mem_wr,
  input  logic             i_reg_we,
  input  logic [RA_W-1:0]  i_rd_addr,
  input  logic             i_flush,
  output logic             o_stall,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic [WIDTH-1:0] o_dmem_addr,
  output logic [WIDTH-1:0] o_dmem_wdata,
  input  logic             i_dmem_ack,
  input  logic [WIDTH-1:0] i_dmem_rdata,
  output logic             o_wb_valid,
  output logic             o_wb_we,
  output logic [RA_W-1:0]  o_wb_rd,
  output logic [WIDTH-1:0] o_wb_data,
  output logic             o_align_err
);

  memState_e        state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             isWrite_q, isWrite_d;
  logic [RA_W-1:0]  rd_q, rd_d;
  logic             regWe_q, regWe_d;
  logic             kill_q, kill_d;
  logic             wbValid_q, wbValid_d;
  logic             wbWe_q, wbWe_d;
  logic [RA_W-1:0]  wbRd_q, wbRd_d;
  logic [WIDTH-1:0] wbData_q, wbData_d;
  logic             isMem;
`ifdef MEM_ALIGN_CHECK_EN
  logic             alignErr_q, alignErr_d;
`endif

  // A load flag wins over a store flag when both are set.
  assign isMem = i_mem_rd | i_mem_wr;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    isWrite_d = isWrite_q;
    rd_d      = rd_q;
    regWe_d   = regWe_q;
    kill_d    = kill_q;
    wbValid_d = 1'b0;
    wbWe_d    = 1'b0;
    wbRd_d    = wbRd_q;
    wbData_d  = wbData_q;
`ifdef MEM_ALIGN_CHECK_EN
    alignErr_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_valid && !i_flush) begin
          if (isMem) begin
`ifdef MEM_ALIGN_CHECK_EN
            if (i_alu_rslt[1:0] != 2'b00) begin
              wbValid_d  = 1'b1;
              wbRd_d     = i_rd_addr;
              wbData_d   = i_alu_rslt;
              alignErr_d = 1'b1;
            end else
`endif
            begin
              state_d   = ACCESS;
              addr_d    = {i_alu_rslt[WIDTH-1:2], 2'b00};
              wdata_d   = i_store_data;
              isWrite_d = i_mem_wr & ~i_mem_rd;
              rd_d      = i_rd_addr;
              regWe_d   = i_reg_we;
              kill_d    = 1'b0;
            end
          end else begin
            wbValid_d = 1'b1;
            wbWe_d    = i_reg_we;
            wbRd_d    = i_rd_addr;
            wbData_d  = i_alu_rslt;
          end
        end
      end
      ACCESS: begin
        // A flush never aborts the bus transaction; it only suppresses the packet.
        if (i_flush) kill_d = 1'b1;
        if (i_dmem_ack) begin
          state_d   = IDLE;
          wbValid_d = ~(kill_q | i_flush);
          wbWe_d    = ~(kill_q | i_flush) & ~isWrite_q & regWe_q;
          wbRd_d    = rd_q;
          wbData_d  = isWrite_q ? addr_q : i_dmem_rdata;
          kill_d    = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      isWrite_q <= 1'b0;
      rd_q      <= '0;
      regWe_q   <= 1'b0;
      kill_q    <= 1'b0;
      wbValid_q <= 1'b0;
      wbWe_q    <= 1'b0;
      wbRd_q    <= '0;
      wbData_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      isWrite_q <= isWrite_d;
      rd_q      <= rd_d;
      regWe_q   <= regWe_d;
      kill_q    <= kill_d;
      wbValid_q <= wbValid_d;
      wbWe_q    <= wbWe_d;
      wbRd_q    <= wbRd_d;
      wbData_q  <= wbData_d;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) alignErr_q <= 1'b0;
    else       alignErr_q <= alignErr_d;
  end
  assign o_align_err = alignErr_q;
`else
  assign o_align_err = 1'b0;
`endif

  assign o_stall      = (state_q == ACCESS);
  assign o_dmem_req   = (state_q == ACCESS);
  assign o_dmem_we    = isWrite_q;
  assign o_dmem_addr  = addr_q;
  assign o_dmem_wdata = wdata_q;
  assign o_wb_valid   = wbValid_q;
  assign o_wb_we      = wbWe_q;
  assign o_wb_rd      = wbRd_q;
  assign o_wb_data    = wbData_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage; inputs change on negedge, outputs checked on negedge.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             validIn, memRd, memWr, regWe, flush, dmemAck;
  logic [WIDTH-1:0] aluRslt, storeData, dmemRdata;
  logic [RA_W-1:0]  rdAddr;
  logic             stall, dmemReq, dmemWe, wbValid, wbWe, alignErr;
  logic [WIDTH-1:0] dmemAddr, dmemWdata, wbData;
  logic [RA_W-1:0]  wbRd;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .reset(reset),
    .i_valid(validIn), .i_alu_rslt(aluRslt), .i_store_data(storeData),
    .i_mem_rd(memRd), .i_mem_wr(memWr), .i_reg_we(regWe), .i_rd_addr(rdAddr),
    .i_flush(flush), .o_stall(stall),
    .o_dmem_req(dmemReq), .o_dmem_we(dmemWe), .o_dmem_addr(dmemAddr),
    .o_dmem_wdata(dmemWdata), .i_dmem_ack(dmemAck), .i_dmem_rdata(dmemRdata),
    .o_wb_valid(wbValid), .o_wb_we(wbWe), .o_wb_rd(wbRd), .o_wb_data(wbData),
    .o_align_err(alignErr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Present one instruction for a single cycle, then return to idle inputs.
  task automatic applyStimulus(input logic rd, input logic wr, input logic we,
                               input logic [RA_W-1:0] dst, input logic [31:0] alu,
                               input logic [31:0] sdata);
    validIn = 1'b1; memRd = rd; memWr = wr; regWe = we;
    rdAddr = dst; aluRslt = alu; storeData = sdata;
    @(negedge clk);
    validIn = 1'b0; memRd = 1'b0; memWr = 1'b0; regWe = 1'b0;
  endtask

  initial begin
    reset = 1'b1; validIn = 1'b0; memRd = 1'b0; memWr = 1'b0; regWe = 1'b0;
    flush = 1'b0; dmemAck = 1'b0; aluRslt = '0; storeData = '0; dmemRdata = '0; rdAddr = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_stall", 32'(stall), 32'h0);
    checkOutput("reset_req", 32'(dmemReq), 32'h0);
    checkOutput("reset_wbvalid", 32'(wbValid), 32'h0);
    checkOutput("reset_wbdata", wbData, 32'h0);
    checkOutput("reset_alignerr", 32'(alignErr), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // ALU pass-through
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_00FF, 32'h0);
    checkOutput("alu_wbvalid", 32'(wbValid), 32'h1);
    checkOutput("alu_wbwe", 32'(wbWe), 32'h1);
    checkOutput("alu_wbrd", 32'(wbRd), 32'd5);
    checkOutput("alu_wbdata", wbData, 32'h0000_00FF);
    checkOutput("alu_stall", 32'(stall), 32'h0);
    @(negedge clk);
    checkOutput("alu_wbpulse", 32'(wbValid), 32'h0);

    // Load with a three-cycle memory
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0100, 32'h0);
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("ld_req%0d", c), 32'(dmemReq), 32'h1);
      checkOutput($sformatf("ld_stall%0d", c), 32'(stall), 32'h1);
      checkOutput($sformatf("ld_addr%0d", c), dmemAddr, 32'h0000_0100);
      checkOutput($sformatf("ld_we%0d", c), 32'(dmemWe), 32'h0);
      checkOutput($sformatf("ld_nowb%0d", c), 32'(wbValid), 32'h0);
      if (c == 2) begin dmemAck = 1'b1; dmemRdata = 32'hDEAD_BEEF; end
      @(negedge clk);
    end
    dmemAck = 1'b0;
    checkOutput("ld_reqdrop", 32'(dmemReq), 32'h0);
    checkOutput("ld_stalldrop", 32'(stall), 32'h0);
    checkOutput("ld_wbvalid", 32'(wbValid), 32'h1);
    checkOutput("ld_wbwe", 32'(wbWe), 32'h1);
    checkOutput("ld_wbrd", 32'(wbRd), 32'd7);
    checkOutput("ld_wbdata", wbData, 32'hDEAD_BEEF);
    @(negedge clk);

    // Store with immediate ack
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd3, 32'h0000_0020, 32'h0000_1234);
    checkOutput("st_req", 32'(dmemReq), 32'h1);
    checkOutput("st_we", 32'(dmemWe), 32'h1);
    checkOutput("st_addr", dmemAddr, 32'h0000_0020);
    checkOutput("st_wdata", dmemWdata, 32'h0000_1234);
    dmemAck = 1'b1;
    @(negedge clk);
    dmemAck = 1'b0;
    checkOutput("st_reqdrop", 32'(dmemReq), 32'h0);
    checkOutput("st_wbvalid", 32'(wbValid), 32'h1);
    checkOutput("st_wbwe", 32'(wbWe), 32'h0);
    @(negedge clk);

    // Flush in the 2nd ACCESS cycle of a load, ack in the 4th, then back-to-back ALU op
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_0040, 32'h0);
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("fl_req%0d", c), 32'(dmemReq), 32'h1);
      flush = (c == 1);
      dmemAck = (c == 3);
      dmemRdata = 32'h0000_0055;
      @(negedge clk);
    end
    flush = 1'b0; dmemAck = 1'b0;
    checkOutput("fl_reqdrop", 32'(dmemReq), 32'h0);
    checkOutput("fl_nowb", 32'(wbValid), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd2, 32'h0000_00AB, 32'h0);
    checkOutput("fl_next_wbvalid", 32'(wbValid), 32'h1);
    checkOutput("fl_next_wbdata", wbData, 32'h0000_00AB);

    // Flush in IDLE drops the incoming instruction
    flush = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd4, 32'h0000_0011, 32'h0);
    flush = 1'b0;
    checkOutput("idleflush_nowb", 32'(wbValid), 32'h0);

    // Reset mid-access (rd and wr both set must behave as a load), then a late ack
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd6, 32'h0000_0080, 32'h0000_9999);
    checkOutput("rst_req", 32'(dmemReq), 32'h1);
    checkOutput("rst_rdwr_isload", 32'(dmemWe), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_reqdrop", 32'(dmemReq), 32'h0);
    checkOutput("rst_stalldrop", 32'(stall), 32'h0);
    dmemAck = 1'b1; dmemRdata = 32'h1111_2222;
    @(negedge clk);
    dmemAck = 1'b0;
    checkOutput("lateack_nowb", 32'(wbValid), 32'h0);
    checkOutput("lateack_nostall", 32'(stall), 32'h0);

    // Misaligned load at 0x102
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd8, 32'h0000_0102, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    checkOutput("mis_noreq", 32'(dmemReq), 32'h0);
    checkOutput("mis_alignerr", 32'(alignErr), 32'h1);
    checkOutput("mis_wbvalid", 32'(wbValid), 32'h1);
    checkOutput("mis_wbwe", 32'(wbWe), 32'h0);
    @(negedge clk);
    checkOutput("mis_errpulse", 32'(alignErr), 32'h0);
`else
    checkOutput("mis_req", 32'(dmemReq), 32'h1);
    checkOutput("mis_addr", dmemAddr, 32'h0000_0100);
    checkOutput("mis_noalignerr", 32'(alignErr), 32'h0);
    dmemAck = 1'b1; dmemRdata = 32'hCAFE_0001;
    @(negedge clk);
    dmemAck = 1'b0;
    checkOutput("mis_wbdata", wbData, 32'hCAFE_0001);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
